// File: rtl/types_pkg.sv
// Memory functional-unit types: RV32I load/store func3 codes, data-memory request/response records
// and the shared misalignment rule.
package types_pkg;

  localparam int DMEM_ROB_W  = 5;
  localparam int DMEM_PREG_W = 7;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef struct packed {
    logic [31:0]             addr;
    logic [2:0]              func3;
    logic [DMEM_PREG_W-1:0]  pd;
    logic [DMEM_ROB_W-1:0]   rob;
  } dmem_ld_req_t;

  typedef struct packed {
    logic [31:0]             data;
    logic [DMEM_PREG_W-1:0]  pd;
    logic [DMEM_ROB_W-1:0]   rob;
    logic                    err;
  } dmem_rsp_t;

  // Store encodings share values with lh/lw, so one rule covers both directions.
  function automatic logic dmem_misaligned(input logic [2:0] func3, input logic [1:0] addr_lo);
    case (func3)
      F3_LH, F3_LHU: return addr_lo[0];
      F3_LW:         return addr_lo != 2'b00;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_extend.sv
// Load data extension: picks byte/half/word from 4 big-endian raw bytes and sign/zero-extends per func3.
// Combinational, no backpressure; also reports whether the access is misaligned.
module dmem_load_extend
  import types_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  func3,
  output logic [31:0] data,
  output logic        misalign
);

  // raw[31:24] is the byte at the load address, raw[23:16] the next one, and so on.
  always_comb begin
    data = '0;
    case (func3)
      F3_LB:   data = {{24{raw[31]}}, raw[31:24]};
      F3_LH:   data = {{16{raw[31]}}, raw[31:16]};
      F3_LW:   data = raw;
      F3_LBU:  data = {24'b0, raw[31:24]};
      F3_LHU:  data = {16'b0, raw[31:16]};
      default: data = '0;
    endcase
  end

  assign misalign = dmem_misaligned(func3, addr_lo);

endmodule

// File: rtl/dmem_pipelined.sv
// Pipelined big-endian data memory: one load and one store per cycle, loads answer LOAD_LATENCY cycles after acceptance.
// stall = rsp_valid && !rsp_ready freezes every load stage; stores never stall. DMEM_MISALIGN_CHK_EN enables misalign checks.
module dmem_pipelined
  import types_pkg::*;
#(
  parameter int unsigned MEM_BYTES    = 131072,
  parameter int unsigned LOAD_LATENCY = 2,
  parameter int unsigned ROB_W        = DMEM_ROB_W,
  parameter int unsigned PREG_W       = DMEM_PREG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_req_valid,
  output logic              ld_req_ready,
  input  logic [31:0]       ld_req_addr,
  input  logic [2:0]        ld_req_func3,
  input  logic [PREG_W-1:0] ld_req_pd,
  input  logic [ROB_W-1:0]  ld_req_rob,
  input  logic              st_valid,
  input  logic [31:0]       st_addr,
  input  logic [2:0]        st_func3,
  input  logic [31:0]       st_data,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [PREG_W-1:0] rsp_pd,
  output logic [ROB_W-1:0]  rsp_rob,
  output logic              rsp_err,
  output logic              st_err
);

  localparam int AW   = $clog2(MEM_BYTES);
  localparam int LAST = LOAD_LATENCY - 1;

  logic [7:0]    mem [MEM_BYTES];

  logic          s_vld [LOAD_LATENCY];
  dmem_ld_req_t  s_req [LOAD_LATENCY];
  logic          rsp_vld_q;
  dmem_rsp_t     rsp_q;
  dmem_rsp_t     rsp_nxt;
  logic          stall;

  logic [AW-1:0] st_base;
  logic [AW-1:0] ld_base;
  logic [AW-1:0] st_baddr [4];
  logic [AW-1:0] ld_baddr [4];
  logic [3:0]    st_mask;
  logic [7:0]    st_byte [4];
  logic [3:0]    st_be;
  logic          st_drop;
  logic          st_err_q;
  logic [31:0]   ld_raw;
  logic [31:0]   ext_data;
  logic          ext_mis;

  assign stall        = rsp_vld_q && !rsp_ready;
  assign ld_req_ready = !stall;

  assign st_base = st_addr[AW-1:0];
  assign ld_base = s_req[LAST].addr[AW-1:0];

  // Byte addresses wrap modulo MEM_BYTES simply by staying AW bits wide.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      st_baddr[i] = st_base + AW'(i);
      ld_baddr[i] = ld_base + AW'(i);
    end
  end

  // Big-endian: the most significant selected byte goes to the lowest address.
  always_comb begin
    st_mask = 4'b0000;
    for (int j = 0; j < 4; j++) st_byte[j] = 8'h00;
    case (st_func3)
      F3_SB: begin
        st_mask    = 4'b0001;
        st_byte[0] = st_data[7:0];
      end
      F3_SH: begin
        st_mask    = 4'b0011;
        st_byte[0] = st_data[15:8];
        st_byte[1] = st_data[7:0];
      end
      F3_SW: begin
        st_mask    = 4'b1111;
        st_byte[0] = st_data[31:24];
        st_byte[1] = st_data[23:16];
        st_byte[2] = st_data[15:8];
        st_byte[3] = st_data[7:0];
      end
      default: st_mask = 4'b0000;
    endcase
  end

`ifdef DMEM_MISALIGN_CHK_EN
  assign st_drop = st_valid && (|st_mask) && dmem_misaligned(st_func3, st_addr[1:0]);
`else
  assign st_drop = 1'b0;
`endif

  assign st_be = (st_valid && !st_drop) ? st_mask : 4'b0000;

  // Stores are blocked while reset is low, so a store in the reset cycle is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_err_q <= 1'b0;
    end else begin
      st_err_q <= st_drop;
      for (int j = 0; j < 4; j++) begin
        if (st_be[j]) mem[st_baddr[j]] <= st_byte[j];
      end
    end
  end

  assign st_err = st_err_q;

  // Array read for the load entering the response register, with same-edge store bytes merged in.
  always_comb begin
    ld_raw = '0;
    for (int i = 0; i < 4; i++) begin
      ld_raw[8*(3-i) +: 8] = mem[ld_baddr[i]];
      for (int j = 0; j < 4; j++) begin
        if (st_be[j] && (st_baddr[j] == ld_baddr[i])) ld_raw[8*(3-i) +: 8] = st_byte[j];
      end
    end
  end

  dmem_load_extend u_ext (
    .raw      (ld_raw),
    .addr_lo  (s_req[LAST].addr[1:0]),
    .func3    (s_req[LAST].func3),
    .data     (ext_data),
    .misalign (ext_mis)
  );

  always_comb begin
    rsp_nxt = '{data: ext_data, pd: s_req[LAST].pd, rob: s_req[LAST].rob, err: 1'b0};
`ifdef DMEM_MISALIGN_CHK_EN
    if (ext_mis) begin
      rsp_nxt.data = '0;
      rsp_nxt.err  = 1'b1;
    end
`endif
  end

  // Flush beats stall: everything in flight, including a held response, is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LOAD_LATENCY; i++) begin
        s_vld[i] <= 1'b0;
        s_req[i] <= '0;
      end
      rsp_vld_q <= 1'b0;
      rsp_q     <= '0;
    end else if (flush) begin
      for (int i = 0; i < LOAD_LATENCY; i++) s_vld[i] <= 1'b0;
      rsp_vld_q <= 1'b0;
    end else if (!stall) begin
      s_vld[0] <= ld_req_valid;
      s_req[0] <= '{addr: ld_req_addr, func3: ld_req_func3, pd: ld_req_pd, rob: ld_req_rob};
      for (int i = 1; i < LOAD_LATENCY; i++) begin
        s_vld[i] <= s_vld[i-1];
        s_req[i] <= s_req[i-1];
      end
      rsp_vld_q <= s_vld[LAST];
      if (s_vld[LAST]) rsp_q <= rsp_nxt;
    end
  end

  assign rsp_valid = rsp_vld_q;
  assign rsp_data  = rsp_q.data;
  assign rsp_pd    = rsp_q.pd;
  assign rsp_rob   = rsp_q.rob;
  assign rsp_err   = rsp_q.err;

  logic unused_bits;
  assign unused_bits = ^{st_addr[31:AW], s_req[LAST].addr[31:AW], ext_mis};

endmodule

// File: tb/tb_dmem_pipelined.sv
// Directed bench for dmem_pipelined: stores, all load widths, bypass, backpressure, flush, wrap and async reset.
// Works with or without DMEM_MISALIGN_CHK_EN; expectations switch on the macro.
module tb_dmem_pipelined;
  import types_pkg::*;

  localparam int unsigned MEM_BYTES = 131072;
  localparam int unsigned LAT       = 2;
`ifdef DMEM_MISALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ld_req_valid = 1'b0;
  logic        ld_req_ready;
  logic [31:0] ld_req_addr = '0;
  logic [2:0]  ld_req_func3 = '0;
  logic [6:0]  ld_req_pd = '0;
  logic [4:0]  ld_req_rob = '0;
  logic        st_valid = 1'b0;
  logic [31:0] st_addr = '0;
  logic [2:0]  st_func3 = '0;
  logic [31:0] st_data = '0;
  logic        flush = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic [6:0]  rsp_pd;
  logic [4:0]  rsp_rob;
  logic        rsp_err;
  logic        st_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_pipelined #(
    .MEM_BYTES(MEM_BYTES), .LOAD_LATENCY(LAT), .ROB_W(5), .PREG_W(7)
  ) dut (
    .clk(clk), .reset(reset),
    .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_req_addr(ld_req_addr),
    .ld_req_func3(ld_req_func3), .ld_req_pd(ld_req_pd), .ld_req_rob(ld_req_rob),
    .st_valid(st_valid), .st_addr(st_addr), .st_func3(st_func3), .st_data(st_data),
    .flush(flush),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_pd(rsp_pd), .rsp_rob(rsp_rob), .rsp_err(rsp_err), .st_err(st_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_store(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] data, input logic exp_err);
    @(negedge clk);
    st_valid = 1'b1; st_addr = addr; st_func3 = f3; st_data = data;
    @(negedge clk);
    st_valid = 1'b0;
    chk({tag, ".st_err"}, 32'(st_err), 32'(exp_err));
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [6:0] pd, input logic [4:0] rob,
                         input logic [31:0] exp_data, input logic exp_err);
    int cyc;
    @(negedge clk);
    ld_req_valid = 1'b1; ld_req_addr = addr; ld_req_func3 = f3; ld_req_pd = pd; ld_req_rob = rob;
    @(negedge clk);
    ld_req_valid = 1'b0;
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, ".lat"}, 32'(cyc), 32'(LAT));
    chk({tag, ".data"}, rsp_data, exp_data);
    chk({tag, ".pd"}, 32'(rsp_pd), 32'(pd));
    chk({tag, ".rob"}, 32'(rsp_rob), 32'(rob));
    chk({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
  endtask

  logic [2:0]  w_f3  [5] = '{F3_LB, F3_LBU, F3_LH, F3_LHU, F3_LW};
  logic [31:0] w_exp [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8040, 32'h00008040, 32'h8040C0FF};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    int nrsp;
    int nv;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.rsp_data", rsp_data, 32'd0);
    chk("rst.rsp_pd", 32'(rsp_pd), 32'd0);
    chk("rst.rsp_rob", 32'(rsp_rob), 32'd0);
    chk("rst.rsp_err", 32'(rsp_err), 32'd0);
    chk("rst.st_err", 32'(st_err), 32'd0);
    reset = 1'b1;
    #1;
    chk("rst.ready", 32'(ld_req_ready), 32'd1);

    // Store then load, every width
    do_store("sw1", 32'h100, F3_SW, 32'h8040C0FF, 1'b0);
    for (int i = 0; i < 5; i++)
      do_load($sformatf("ld%0d", i), 32'h100, w_f3[i], 7'(i + 1), 5'(i + 1), w_exp[i], 1'b0);
    do_load("lh102", 32'h102, F3_LH, 7'd6, 5'd6, 32'hFFFFC0FF, 1'b0);
    do_load("lbu103", 32'h103, F3_LBU, 7'd7, 5'd7, 32'h000000FF, 1'b0);
    do_load("badf3", 32'h100, 3'b011, 7'd8, 5'd8, 32'h0, 1'b0);
    do_load("lh101", 32'h101, F3_LH, 7'd9, 5'd9, CHK ? 32'h0 : 32'h000040C0, CHK);

    // Same-cycle store-to-load bypass
    do_store("byp.clr", 32'h200, F3_SW, 32'h0, 1'b0);
    @(negedge clk);
    ld_req_valid = 1'b1; ld_req_addr = 32'h200; ld_req_func3 = F3_LW; ld_req_pd = 7'd40; ld_req_rob = 5'd12;
    @(negedge clk);
    ld_req_valid = 1'b0;
    @(negedge clk);
    st_valid = 1'b1; st_addr = 32'h201; st_func3 = F3_SB; st_data = 32'h123456AB;
    @(negedge clk);
    st_valid = 1'b0;
    chk("byp.vld", 32'(rsp_valid), 32'd1);
    chk("byp.data", rsp_data, 32'h00AB0000);
    chk("byp.pd", 32'(rsp_pd), 32'd40);
    do_load("byp.after", 32'h200, F3_LW, 7'd41, 5'd13, 32'h00AB0000, 1'b0);

    // Backpressure: 4 back-to-back loads, rsp_ready low in cycles 3..5
    for (int i = 0; i < 4; i++)
      do_store($sformatf("bp.st%0d", i), 32'h300 + 32'(4 * i), F3_SW, 32'hC0DE0000 + 32'(i), 1'b0);
    k = 0;
    nrsp = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      rsp_ready = !(c >= 3 && c <= 5);
      ld_req_valid = (k < 4);
      ld_req_addr = 32'h300 + 32'(4 * k);
      ld_req_func3 = F3_LW;
      ld_req_pd = 7'(20 + k);
      ld_req_rob = 5'(k);
      #1;
      chk($sformatf("bp.rdy%0d", c), 32'(ld_req_ready), (c >= 3 && c <= 5) ? 32'd0 : 32'd1);
      if (ld_req_valid && ld_req_ready) k++;
      if (rsp_valid && rsp_ready) begin
        if (nrsp < 4) begin
          chk($sformatf("bp.data%0d", nrsp), rsp_data, 32'hC0DE0000 + 32'(nrsp));
          chk($sformatf("bp.pd%0d", nrsp), 32'(rsp_pd), 32'(20 + nrsp));
          chk($sformatf("bp.rob%0d", nrsp), 32'(rsp_rob), 32'(nrsp));
        end
        nrsp++;
      end
    end
    ld_req_valid = 1'b0;
    rsp_ready = 1'b1;
    chk("bp.issued", 32'(k), 32'd4);
    chk("bp.count", 32'(nrsp), 32'd4);

    // Flush: two loads in flight plus a request in the flush cycle
    @(negedge clk);
    ld_req_valid = 1'b1; ld_req_addr = 32'h300; ld_req_func3 = F3_LW; ld_req_pd = 7'd30; ld_req_rob = 5'd1;
    @(negedge clk);
    ld_req_addr = 32'h304; ld_req_pd = 7'd31; ld_req_rob = 5'd2;
    @(negedge clk);
    ld_req_addr = 32'h308; ld_req_pd = 7'd32; ld_req_rob = 5'd3; flush = 1'b1;
    @(negedge clk);
    ld_req_valid = 1'b0; flush = 1'b0;
    nv = 0;
    for (int c = 0; c < 8; c++) begin
      if (rsp_valid) nv++;
      @(negedge clk);
    end
    chk("fl.none", 32'(nv), 32'd0);
    do_load("fl.after", 32'h308, F3_LW, 7'd33, 5'd4, 32'hC0DE0002, 1'b0);

    // Address wrap at the top of memory
    do_store("wrap.z0", 32'h0, F3_SW, 32'h0, 1'b0);
    do_store("wrap.z1", 32'(MEM_BYTES - 4), F3_SW, 32'h0, 1'b0);
    do_store("wrap.sw", 32'(MEM_BYTES - 2), F3_SW, 32'h11223344, CHK);
    @(negedge clk);
    chk("wrap.st_err_end", 32'(st_err), 32'd0);
    do_load("wrap.lw", 32'(MEM_BYTES - 2), F3_LW, 7'd50, 5'd20, CHK ? 32'h0 : 32'h11223344, CHK);
    do_load("wrap.lh0", 32'h0, F3_LH, 7'd51, 5'd21, CHK ? 32'h0 : 32'h00003344, 1'b0);
    do_load("wrap.lhtop", 32'(MEM_BYTES - 2), F3_LH, 7'd52, 5'd22, CHK ? 32'h0 : 32'h00001122, 1'b0);

    // Async reset with loads in flight; store during reset is lost
    do_store("ar.st", 32'h400, F3_SW, 32'h12345678, 1'b0);
    @(negedge clk);
    ld_req_valid = 1'b1; ld_req_addr = 32'h400; ld_req_func3 = F3_LW; ld_req_pd = 7'd60; ld_req_rob = 5'd30;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    ld_req_valid = 1'b0;
    chk("ar.pre_vld", 32'(rsp_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar.vld_drop", 32'(rsp_valid), 32'd0);
    chk("ar.data_clr", rsp_data, 32'd0);
    chk("ar.ready", 32'(ld_req_ready), 32'd1);
    @(negedge clk);
    st_valid = 1'b1; st_addr = 32'h400; st_func3 = F3_SW; st_data = 32'hDEADBEEF;
    @(negedge clk);
    st_valid = 1'b0;
    reset = 1'b1;
    nv = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid) nv++;
    end
    chk("ar.no_stale", 32'(nv), 32'd0);
    do_load("ar.after", 32'h400, F3_LW, 7'd61, 5'd31, 32'h12345678, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
